bsg_mem_1r1w_sync_mask_write_bit_bypass: RTL



---
 rtl/bsg_mem_1r1w_sync_mask_write_bit_bypass.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/bsg_mem_1r1w_sync_mask_write_bit_bypass.sv
// Synchronous 1R1W bit-masked register file with write-first read forwarding,
// an optional post-reset init sweep and out-of-range address protection.
// Optional build macro: BSG_MEM_1R1W_BYPASS_ADDR_ERR_EN enables the sticky
// out-of-range error flag on err_o (otherwise err_o is tied low).
module bsg_mem_1r1w_sync_mask_write_bit_bypass #(
    parameter int unsigned        width_p         = 64,
    parameter int unsigned        els_p           = 64,
    parameter int unsigned        init_on_reset_p = 1,
    parameter logic [width_p-1:0] init_val_p      = '0,
    localparam int unsigned       addr_width_lp   = (els_p > 1) ? $clog2(els_p) : 1
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    output logic                     ready_o,
    input  logic                     w_v_i,
    input  logic [width_p-1:0]       w_mask_i,
    input  logic [addr_width_lp-1:0] w_addr_i,
    input  logic [width_p-1:0]       w_data_i,
    input  logic                     r_v_i,
    input  logic [addr_width_lp-1:0] r_addr_i,
    output logic                     r_v_o,
    output logic [width_p-1:0]       r_data_o,
    output logic                     err_o
);

    typedef enum logic [1:0] {StInit, StIdle, StReady} state_e;

    localparam state_e reset_state_lc = (init_on_reset_p != 0) ? StInit : StIdle;
    localparam logic [addr_width_lp-1:0] last_addr_lc = addr_width_lp'(els_p - 1);

    state_e                   state_q, state_d;
    logic [addr_width_lp-1:0] cnt_q, cnt_d;
    logic                     ready_q;
    logic                     r_v_q;
    logic [width_p-1:0]       r_data_q;
    logic [width_p-1:0]       mem [els_p];

    logic                     w_in_range, r_in_range;
    logic                     w_fire, r_fire;
    logic [width_p-1:0]       w_old, r_old, w_merged, r_word;

    // Request qualification, masked merge and write-first read forwarding
    always_comb begin
        w_in_range = (32'(w_addr_i) < els_p);
        r_in_range = (32'(r_addr_i) < els_p);
        w_fire     = ready_q & w_v_i & w_in_range;
        r_fire     = ready_q & r_v_i;
        w_old      = '0;
        r_old      = '0;
        if (w_in_range) w_old = mem[w_addr_i];
        if (r_in_range) r_old = mem[r_addr_i];
        w_merged   = (w_data_i & w_mask_i) | (w_old & ~w_mask_i);
        // Out-of-range reads return zero rather than whatever the index aliases
        r_word     = '0;
        if (r_in_range) r_word = (w_fire && (w_addr_i == r_addr_i)) ? w_merged : r_old;
    end

    // Next-state logic for the init sweep / ready sequencing
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StInit: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == last_addr_lc) begin
                    state_d = StReady;
                    cnt_d   = '0;
                end
            end
            StIdle:  state_d = StReady;
            StReady: state_d = StReady;
            default: state_d = reset_state_lc;
        endcase
    end

    // Control state; ready is registered so it has no path from the inputs
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= reset_state_lc;
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= (state_d == StReady);
        end
    end

    // Array write port: sweep writes own the port until ready
    always_ff @(posedge clk_i) begin
        if (state_q == StInit) begin
            mem[cnt_q] <= init_val_p;
        end else if (w_fire) begin
            mem[w_addr_i] <= w_merged;
        end
    end

    // Read port: one-cycle latency, data held between reads
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_v_q    <= 1'b0;
            r_data_q <= '0;
        end else begin
            r_v_q <= r_fire;
            if (r_fire) r_data_q <= r_word;
        end
    end

    assign ready_o  = ready_q;
    assign r_v_o    = r_v_q;
    assign r_data_o = r_data_q;

`ifdef BSG_MEM_1R1W_BYPASS_ADDR_ERR_EN
    logic err_q;
    logic w_oob, r_oob;

    assign w_oob = ready_q & w_v_i & ~w_in_range;
    assign r_oob = ready_q & r_v_i & ~r_in_range;

    // Sticky error flag, cleared only by reset
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            err_q <= 1'b0;
        end else if (w_oob || r_oob) begin
            err_q <= 1'b1;
        end
    end

    assign err_o = err_q;

`ifndef SYNTHESIS
    // Report each offending access in simulation
    always_ff @(posedge clk_i) begin
        if (!reset_i && w_oob) $error("%m: write address %0d out of range", w_addr_i);
        if (!reset_i && r_oob) $error("%m: read address %0d out of range", r_addr_i);
    end
`endif
`else
    assign err_o = 1'b0;
`endif

`ifndef SYNTHESIS
    initial begin
        $display("%m: width_p=%0d els_p=%0d init_on_reset_p=%0d",
                 width_p, els_p, init_on_reset_p);
    end
`endif

endmodule
